// File: rtl/grayscale_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one grayscale stage between two RGB input FIFOs.
// Optional starvation timeout enabled by defining GS_ARB_TIMEOUT_EN.
module grayscale_frame_arbiter #(
  parameter int FIFO_DWIDTH_IN = 24,
  parameter int WIDTH          = 720,
  parameter int HEIGHT         = 540,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      in0_rd_en,
  input  logic [FIFO_DWIDTH_IN-1:0] in0_dout,
  input  logic                      in0_empty,
  output logic                      in1_rd_en,
  input  logic [FIFO_DWIDTH_IN-1:0] in1_dout,
  input  logic                      in1_empty,
  input  logic                      gs_rd_en,
  output logic [FIFO_DWIDTH_IN-1:0] gs_dout,
  output logic                      gs_empty,
  output logic                      active_src,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      frame_abort
);

  localparam int FRAME_PIXELS = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pix_cnt;
  logic             last_grant;
  logic             rd_fire;
  logic             last_read;
  logic             grant_src;
  logic             stall_abort;

  assign busy      = (state != IDLE);
  assign grant_src = (state_nxt == GRANT1);

  always_comb begin
    state_nxt = state;
    gs_dout   = '0;
    gs_empty  = 1'b1;
    in0_rd_en = 1'b0;
    in1_rd_en = 1'b0;
    case (state)
      IDLE: begin
        // A tie goes to whichever source did not get the previous frame.
        if (!in0_empty && !in1_empty) state_nxt = last_grant ? GRANT0 : GRANT1;
        else if (!in0_empty)          state_nxt = GRANT0;
        else if (!in1_empty)          state_nxt = GRANT1;
      end
      GRANT0: begin
        gs_dout   = in0_dout;
        gs_empty  = in0_empty;
        in0_rd_en = gs_rd_en & ~in0_empty;
      end
      GRANT1: begin
        gs_dout   = in1_dout;
        gs_empty  = in1_empty;
        in1_rd_en = gs_rd_en & ~in1_empty;
      end
      default: state_nxt = IDLE;
    endcase
    rd_fire   = in0_rd_en | in1_rd_en;
    last_read = rd_fire && (pix_cnt == LAST_PIX);
    if (last_read || stall_abort) state_nxt = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      last_grant <= 1'b1;
      active_src <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= last_read;
      if (state == IDLE && state_nxt != IDLE) begin
        pix_cnt    <= '0;
        active_src <= grant_src;
        last_grant <= grant_src;
      end else if (last_read || stall_abort) begin
        pix_cnt <= '0;
      end else if (rd_fire) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

`ifdef GS_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               src_empty;
  logic               abort_q;

  // last_grant is left untouched on abort so the other source wins the next tie.
  assign src_empty   = (state == GRANT0) ? in0_empty : in1_empty;
  assign stall_abort = busy && src_empty && (stall_cnt == STALL_LAST);
  assign frame_abort = abort_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      abort_q   <= 1'b0;
    end else begin
      abort_q <= stall_abort;
      if (!busy || !src_empty || stall_abort) stall_cnt <= '0;
      else                                    stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_abort = 1'b0;
  assign frame_abort = 1'b0;
`endif

endmodule

// File: tb/tb_grayscale_frame_arbiter.sv
// Scoreboard bench for grayscale_frame_arbiter: behavioural input FIFOs, expected pixel queue
// filled by the stimulus, and an independent monitor comparing every read pixel and its source.
module tb_grayscale_frame_arbiter;

  localparam int DW = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in0_rd_en, in1_rd_en;
  logic [DW-1:0] in0_dout = '0, in1_dout = '0;
  logic          in0_empty = 1'b1, in1_empty = 1'b1;
  logic          gs_rd_en = 1'b0;
  logic [DW-1:0] gs_dout;
  logic          gs_empty, active_src, busy, frame_done, frame_abort;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW:0]   exp_q[$];
  logic          grants[$];

  int vectors = 0;
  int miscompares = 0;
  int done_cnt, abort_cnt, rd0_cnt, rd1_cnt, cyc, last_rd_cyc, done_cyc, viol;
  bit toggle_mode = 1'b0;
  bit prev_busy = 1'b0;

  grayscale_frame_arbiter #(
    .FIFO_DWIDTH_IN(DW), .WIDTH(4), .HEIGHT(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset),
    .in0_rd_en(in0_rd_en), .in0_dout(in0_dout), .in0_empty(in0_empty),
    .in1_rd_en(in1_rd_en), .in1_dout(in1_dout), .in1_empty(in1_empty),
    .gs_rd_en(gs_rd_en), .gs_dout(gs_dout), .gs_empty(gs_empty),
    .active_src(active_src), .busy(busy),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every accepted read must match the next expected pixel and its source.
  always @(negedge clock) begin : monitor
    logic [DW:0] e;
    if (!reset && gs_rd_en && !gs_empty) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected read: got 0x%0h, expected no read", gs_dout);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pixel data", 32'(gs_dout), 32'(e[DW-1:0]));
        checkOutput("pixel source", 32'(active_src), 32'(e[DW]));
      end
    end
  end

  task automatic refresh();
    in0_empty = (q0.size() == 0);
    in1_empty = (q1.size() == 0);
    in0_dout  = (q0.size() != 0) ? q0[0] : '0;
    in1_dout  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  task automatic loadFifo(input bit src, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (src) q1.push_back(base + DW'(i));
      else     q0.push_back(base + DW'(i));
    end
    refresh();
  endtask

  task automatic expectPixels(input bit src, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({src, base + DW'(i)});
  endtask

  task automatic clearStats();
    done_cnt = 0; abort_cnt = 0; rd0_cnt = 0; rd1_cnt = 0; viol = 0;
    last_rd_cyc = -1; done_cyc = -1;
    grants.delete();
  endtask

  task automatic applyStimulus(input int n);
    bit r0, r1;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      r0 = in0_rd_en;
      r1 = in1_rd_en;
      if (frame_done) begin done_cnt++; done_cyc = cyc; end
      if (frame_abort) abort_cnt++;
      if (busy && !prev_busy) grants.push_back(active_src);
      prev_busy = busy;
      if (r0) begin rd0_cnt++; if (rd0_cnt == 8) last_rd_cyc = cyc; end
      if (r1) rd1_cnt++;
      if (toggle_mode && ((r0 && !gs_rd_en) || (gs_rd_en && busy && !in0_empty && !r0))) viol++;
      @(posedge clock);
      #1;
      if (r0 && q0.size() != 0) void'(q0.pop_front());
      if (r1 && q1.size() != 0) void'(q1.pop_front());
      refresh();
      if (toggle_mode) gs_rd_en = ~gs_rd_en;
      cyc++;
    end
  endtask

  task automatic checkGrants(input string name, input int n, input logic [3:0] pattern);
    checkOutput({name, " grant count"}, 32'(grants.size()), 32'(n));
    for (int i = 0; i < n && i < grants.size(); i++)
      checkOutput($sformatf("%s grant %0d", name, i), 32'(grants[i]), 32'(pattern[i]));
  endtask

  initial begin
    cyc = 0;
    clearStats();
    refresh();
    applyStimulus(3);
    checkOutput("reset gs_empty", 32'(gs_empty), 32'd1);
    checkOutput("reset gs_dout", 32'(gs_dout), 32'd0);
    checkOutput("reset rd_en", 32'({in0_rd_en, in1_rd_en}), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset active_src", 32'(active_src), 32'd0);
    checkOutput("reset pulses", 32'({frame_done, frame_abort}), 32'd0);
    reset = 1'b0;
    gs_rd_en = 1'b1;

    // Round robin: both full, source 0 first after reset, then alternating.
    clearStats();
    loadFifo(1'b0, 24'h000100, 16);
    loadFifo(1'b1, 24'h000200, 16);
    expectPixels(1'b0, 24'h000100, 8);
    expectPixels(1'b1, 24'h000200, 8);
    expectPixels(1'b0, 24'h000108, 8);
    expectPixels(1'b1, 24'h000208, 8);
    applyStimulus(45);
    checkGrants("round robin", 4, 4'b1010);
    checkOutput("round robin frame_done count", 32'(done_cnt), 32'd4);
    checkOutput("round robin reads0", 32'(rd0_cnt), 32'd16);
    checkOutput("round robin reads1", 32'(rd1_cnt), 32'd16);
    checkOutput("round robin drained", 32'(exp_q.size()), 32'd0);

    // Single source.
    clearStats();
    loadFifo(1'b0, 24'h000001, 8);
    expectPixels(1'b0, 24'h000001, 8);
    applyStimulus(14);
    checkGrants("single", 1, 4'b0000);
    checkOutput("single reads0", 32'(rd0_cnt), 32'd8);
    checkOutput("single frame_done count", 32'(done_cnt), 32'd1);
    checkOutput("single back to idle", 32'({busy, gs_empty}), 32'b01);
    checkOutput("single drained", 32'(exp_q.size()), 32'd0);

    // Stall: source 1 holds the grant while empty even with FIFO0 full.
    clearStats();
    loadFifo(1'b1, 24'h000300, 3);
    loadFifo(1'b0, 24'h000400, 8);
    expectPixels(1'b1, 24'h000300, 8);
    expectPixels(1'b0, 24'h000400, 8);
    applyStimulus(14);
    checkOutput("stall busy", 32'(busy), 32'd1);
    checkOutput("stall active_src", 32'(active_src), 32'd1);
    checkOutput("stall no FIFO0 reads", 32'(rd0_cnt), 32'd0);
    loadFifo(1'b1, 24'h000303, 5);
    applyStimulus(20);
    checkGrants("stall", 2, 4'b0001);
    checkOutput("stall reads1", 32'(rd1_cnt), 32'd8);
    checkOutput("stall frame_done count", 32'(done_cnt), 32'd2);
    checkOutput("stall drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: gs_rd_en toggles every cycle.
    clearStats();
    toggle_mode = 1'b1;
    loadFifo(1'b0, 24'h000500, 8);
    expectPixels(1'b0, 24'h000500, 8);
    applyStimulus(25);
    toggle_mode = 1'b0;
    gs_rd_en = 1'b1;
    checkOutput("backpressure reads0", 32'(rd0_cnt), 32'd8);
    checkOutput("backpressure rd_en follow", 32'(viol), 32'd0);
    checkOutput("backpressure frame_done count", 32'(done_cnt), 32'd1);
    checkOutput("backpressure done timing", 32'(done_cyc), 32'(last_rd_cyc + 1));
    checkOutput("backpressure drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a source-1 frame after 5 pixels.
    clearStats();
    loadFifo(1'b1, 24'h000600, 8);
    expectPixels(1'b1, 24'h000600, 5);
    applyStimulus(6);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("midreset gs_empty", 32'(gs_empty), 32'd1);
    checkOutput("midreset rd_en", 32'({in0_rd_en, in1_rd_en}), 32'd0);
    checkOutput("midreset active_src", 32'(active_src), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset FIFO1 left", 32'(q1.size()), 32'd3);
    loadFifo(1'b0, 24'h000700, 8);
    loadFifo(1'b1, 24'h000608, 5);
    expectPixels(1'b0, 24'h000700, 8);
    expectPixels(1'b1, 24'h000605, 8);
    applyStimulus(1);
    reset = 1'b0;
    clearStats();
    prev_busy = 1'b0;
    applyStimulus(24);
    checkGrants("after reset", 2, 4'b0010);
    checkOutput("after reset frame_done count", 32'(done_cnt), 32'd2);
    checkOutput("after reset drained", 32'(exp_q.size()), 32'd0);

    // Starvation: source 0 empties after 3 pixels.
    clearStats();
    loadFifo(1'b0, 24'h000800, 3);
    loadFifo(1'b1, 24'h000900, 8);
    expectPixels(1'b0, 24'h000800, 3);
`ifdef GS_ARB_TIMEOUT_EN
    expectPixels(1'b1, 24'h000900, 8);
    applyStimulus(40);
    checkOutput("timeout abort count", 32'(abort_cnt), 32'd1);
    checkOutput("timeout frame_done count", 32'(done_cnt), 32'd1);
    checkGrants("timeout", 2, 4'b0010);
`else
    applyStimulus(40);
    checkOutput("starve abort count", 32'(abort_cnt), 32'd0);
    checkOutput("starve frame_done count", 32'(done_cnt), 32'd0);
    checkOutput("starve grant held", 32'({busy, active_src}), 32'b10);
    checkOutput("starve no FIFO1 reads", 32'(rd1_cnt), 32'd0);
    checkGrants("starve", 1, 4'b0000);
`endif
    checkOutput("starve drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
